// File: rtl/mant_mult_foil_pipe_pkg.sv
// Shared helpers for the FOIL mantissa multiplier: product width, DRUM
// segment selection, round-to-nearest-even increment and stage-valid encodings.
package mant_mult_pkg;

  localparam int   STAGES      = 3;
  localparam logic STAGE_EMPTY = 1'b0;
  localparam logic STAGE_FULL  = 1'b1;

  function automatic int prod_width(input int mw);
    return 2 * mw + 2;
  endfunction

  function automatic int lod(input logic [63:0] m);
    int p;
    p = 0;
    for (int i = 0; i < 64; i++) begin
      if (m[i]) p = i;
    end
    return p;
  endfunction

  // Values that already fit in k bits are kept exact, which also covers m == 0.
  function automatic int drum_shift(input logic [63:0] m, input int k);
    if (m < (64'd1 << k)) return 0;
    return lod(m) - k + 1;
  endfunction

  function automatic logic rne_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/mant_mult_foil_pipe_if.sv
// Operand/result bus of the mantissa multiplier.
// Handshake: a word moves when valid & ready are both high on a rising clk edge;
// a source holds its valid and data stable until that transfer happens.
interface mant_mult_foil_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  logic               in_valid;
  logic               in_ready;
  logic [EW+MW-1:0]   a_operand;
  logic [EW+MW-1:0]   b_operand;
  logic               approx_en;
  logic               out_valid;
  logic               out_ready;
  logic               normalised;
  logic [MW-1:0]      product_mantissa;
  logic               round_carry;

  modport master (
    output in_valid, a_operand, b_operand, approx_en, out_ready,
    input  in_ready, out_valid, normalised, product_mantissa, round_carry
  );

  modport slave (
    input  in_valid, a_operand, b_operand, approx_en, out_ready,
    output in_ready, out_valid, normalised, product_mantissa, round_carry
  );
endinterface

// File: rtl/mant_mult_foil_pipe_drum_seg.sv
// DRUM segment: leading-one detect, keep the top K bits with the LSB forced to 1,
// and report how far the segment was shifted down.
module drum_seg
  import mant_mult_pkg::*;
#(
  parameter int MW = 23,
  parameter int K  = 9,
  parameter int SW = $clog2(MW + 1)
) (
  input  logic [MW-1:0] m,
  output logic [K-1:0]  t,
  output logic [SW-1:0] s
);

  int sh;

  always_comb begin
    sh = drum_shift(64'(m), K);
    s  = SW'(sh);
    if (sh == 0) t = K'(m);
    else         t = K'(m >> sh) | K'(1);
  end

endmodule

// File: rtl/mant_mult_foil_pipe.sv
// Three-stage FOIL mantissa multiplier: capture/segment, four-term sum,
// normalise and round-to-nearest-even, with a single global stall.
module mant_mult_foil_pipe
  import mant_mult_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int K  = 9
) (
  input logic                 clk,
  input logic                 rst,
  mant_mult_foil_pipe_if.slave bus
);

  localparam int PW = prod_width(MW);
  localparam int SW = $clog2(MW + 1);

  logic advance;

  logic [EW-1:0] a_exp, b_exp;
  logic [MW-1:0] a_man, b_man;
  logic [K-1:0]  a_t, b_t;
  logic [SW-1:0] a_s, b_s;

  logic          s1_valid;
  logic [K-1:0]  s1_ta, s1_tb;
  logic [SW-1:0] s1_sa, s1_sb;
  logic [MW-1:0] s1_ma, s1_mb;
  logic          s1_ha, s1_hb, s1_approx;

  logic          s2_valid;
  logic [PW-1:0] s2_p;

  logic          s3_valid;
  logic          s3_norm;
  logic [MW-1:0] s3_mant;
  logic          s3_carry;

  assign a_exp = bus.a_operand[EW+MW-1:MW];
  assign b_exp = bus.b_operand[EW+MW-1:MW];
  assign a_man = bus.a_operand[MW-1:0];
  assign b_man = bus.b_operand[MW-1:0];

  drum_seg #(.MW(MW), .K(K), .SW(SW)) u_seg_a (.m(a_man), .t(a_t), .s(a_s));
  drum_seg #(.MW(MW), .K(K), .SW(SW)) u_seg_b (.m(b_man), .t(b_t), .s(b_s));

  // S2: hidden-bit terms plus the exact or DRUM M1*M2 term.
  logic [PW-1:0] term_a, term_b, term_c, term_d, p_sum;
  logic [SW:0]   s_sum;

  always_comb begin
    term_a         = '0;
    term_a[2*MW]   = s1_ha & s1_hb;
    term_b         = s1_ha ? (PW'(s1_mb) << MW) : '0;
    term_c         = s1_hb ? (PW'(s1_ma) << MW) : '0;
    s_sum          = {1'b0, s1_sa} + {1'b0, s1_sb};
    if (s1_approx) term_d = (PW'(s1_ta) * PW'(s1_tb)) << s_sum;
    else           term_d = PW'(s1_ma) * PW'(s1_mb);
    p_sum          = term_a + term_b + term_c + term_d;
  end

  // S3: the MSB of the product is dropped after normalisation, so only PW-1 bits matter.
  logic [PW-2:0] n_val;
  logic          lsb, guard, sticky;
  logic [MW:0]   rounded;

  always_comb begin
    n_val   = s2_p[PW-1] ? s2_p[PW-2:0] : {s2_p[PW-3:0], 1'b0};
    lsb     = n_val[PW-1-MW];
    guard   = n_val[PW-2-MW];
    sticky  = |n_val[PW-3-MW:0];
    rounded = {1'b0, n_val[PW-2:PW-1-MW]} + (MW+1)'(rne_up(lsb, guard, sticky));
  end

  assign advance      = !s3_valid | bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= STAGE_EMPTY;
      s1_ta     <= '0;
      s1_tb     <= '0;
      s1_sa     <= '0;
      s1_sb     <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_ha     <= 1'b0;
      s1_hb     <= 1'b0;
      s1_approx <= 1'b0;
      s2_valid  <= STAGE_EMPTY;
      s2_p      <= '0;
      s3_valid  <= STAGE_EMPTY;
      s3_norm   <= 1'b0;
      s3_mant   <= '0;
      s3_carry  <= 1'b0;
    end else if (advance) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ta     <= a_t;
        s1_tb     <= b_t;
        s1_sa     <= a_s;
        s1_sb     <= b_s;
        s1_ma     <= a_man;
        s1_mb     <= b_man;
        s1_ha     <= |a_exp;
        s1_hb     <= |b_exp;
        s1_approx <= bus.approx_en;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_p <= p_sum;
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_norm  <= s2_p[PW-1];
        s3_carry <= rounded[MW];
        s3_mant  <= rounded[MW-1:0];
      end
    end
  end

  assign bus.out_valid        = s3_valid;
  assign bus.normalised       = s3_norm;
  assign bus.product_mantissa = s3_mant;
  assign bus.round_carry      = s3_carry;

endmodule

// File: tb/tb_mant_mult_foil_pipe.sv
// Directed bench for mant_mult_foil_pipe: exact/approximate products, rounding,
// backpressure and asynchronous reset.
module tb_mant_mult_foil_pipe;

  localparam int EW = 8;
  localparam int MW = 23;
  localparam int OW = EW + MW;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [MW+1:0] exp_q[$];

  mant_mult_foil_pipe_if #(.EW(EW), .MW(MW)) bus ();

  mant_mult_foil_pipe #(.EW(EW), .MW(MW), .K(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required finish before 200000");
    $fatal(1);
  end

  // Drives one operand pair into an idle pipe and waits (bounded) for its result.
  task automatic send_one(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic ap,
                          output logic seen, output int lat, output logic [MW+1:0] got);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.a_operand = a;
    bus.b_operand = b;
    bus.approx_en = ap;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    got  = '0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = i;
        got  = {bus.normalised, bus.round_carry, bus.product_mantissa};
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;
    bus.approx_en = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.normalised, bus.round_carry, bus.product_mantissa} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b n=%0b c=%0b m=%h, required all 0",
               bus.out_valid, bus.normalised, bus.round_carry, bus.product_mantissa);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_exact();
    logic [OW-1:0]   av[6], bv[6];
    logic [MW+1:0]   ev[6];
    logic            seen;
    int              lat;
    logic [MW+1:0]   got;
    av = '{{8'h7F, 23'h000000}, {8'h7F, 23'h400000}, {8'h00, 23'h400000},
           {8'h7F, 23'h000003}, {8'h7F, 23'h400000}, {8'h00, 23'h000000}};
    bv = '{{8'h7F, 23'h000000}, {8'h7F, 23'h400000}, {8'h00, 23'h400000},
           {8'h7F, 23'h000005}, {8'h7F, 23'h000003}, {8'h00, 23'h000000}};
    ev = '{{2'b00, 23'h000000}, {2'b10, 23'h100000}, {2'b00, 23'h200000},
           {2'b00, 23'h000008}, {2'b00, 23'h400004}, {2'b00, 23'h000000}};
    for (int i = 0; i < 6; i++) begin
      send_one(av[i], bv[i], 1'b0, seen, lat, got);
      checks++;
      if (!seen || lat != 3 || got !== ev[i]) begin
        errors++;
        $display("FAIL exact_%0d: seen=%0b lat=%0d {n,c,m}=%h, required lat=3 {n,c,m}=%h",
                 i, seen, lat, got, ev[i]);
      end
    end
  endtask

  task automatic test_approx();
    logic [OW-1:0]   av[4], bv[4];
    logic [MW+1:0]   ev[4];
    logic            seen;
    int              lat;
    logic [MW+1:0]   got;
    av = '{{8'h7F, 23'h400000}, {8'h7F, 23'h400000}, {8'h7F, 23'h000003}, {8'h7F, 23'h400000}};
    bv = '{{8'h7F, 23'h400000}, {8'h7F, 23'h200000}, {8'h7F, 23'h000005}, {8'h7F, 23'h000003}};
    ev = '{{2'b10, 23'h102010}, {2'b00, 23'h702010}, {2'b00, 23'h000008}, {2'b00, 23'h400005}};
    for (int i = 0; i < 4; i++) begin
      send_one(av[i], bv[i], 1'b1, seen, lat, got);
      checks++;
      if (!seen || lat != 3 || got !== ev[i]) begin
        errors++;
        $display("FAIL approx_%0d: seen=%0b lat=%0d {n,c,m}=%h, required lat=3 {n,c,m}=%h",
                 i, seen, lat, got, ev[i]);
      end
    end
  endtask

  task automatic test_rounding();
    logic            seen;
    int              lat;
    logic [MW+1:0]   got;
    send_one({8'h7F, 23'h000001}, {8'h7F, 23'h400000}, 1'b0, seen, lat, got);
    checks++;
    if (!seen || got !== {2'b00, 23'h400002}) begin
      errors++;
      $display("FAIL rne_tie_odd: seen=%0b {n,c,m}=%h, required %h", seen, got, {2'b00, 23'h400002});
    end
    send_one({8'h7F, 23'h000001}, {8'h00, 23'h7FFFFF}, 1'b0, seen, lat, got);
    checks++;
    if (!seen || got !== {2'b01, 23'h000000}) begin
      errors++;
      $display("FAIL round_carry_wrap: seen=%0b {n,c,m}=%h, required %h", seen, got, {2'b01, 23'h000000});
    end
  endtask

  task automatic test_back_to_back();
    logic [MW-1:0] mants[6];
    int            sent = 0;
    int            recv = 0;
    int            cyc  = 0;
    int            extra = 0;
    logic          held_valid = 1'b0;
    logic [MW+1:0] held = '0;
    logic [MW+1:0] obs, want;
    mants = '{23'h000001, 23'h000002, 23'h000003, 23'h123456, 23'h7FFFFF, 23'h00ABCD};
    exp_q.delete();
    while ((sent < 6 || recv < 6) && cyc < 60) begin
      @(negedge clk);
      bus.in_valid  = (sent < 6);
      bus.a_operand = {8'h7F, mants[sent < 6 ? sent : 0]};
      bus.b_operand = {8'h7F, 23'h000000};
      bus.approx_en = 1'b0;
      bus.out_ready = !(cyc >= 2 && cyc <= 8);
      #1;
      obs = {bus.normalised, bus.round_carry, bus.product_mantissa};
      if (cyc == 2) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_c2: in_ready=%0b, required 1", bus.in_ready);
        end
      end
      if (cyc == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_c3: in_ready=%0b, required 0", bus.in_ready);
        end
      end
      if (held_valid) begin
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== held) begin
          errors++;
          $display("FAIL b2b_hold c%0d: v=%0b data=%h, required v=1 data=%h", cyc, bus.out_valid, obs, held);
        end
      end
      held_valid = 1'b0;
      if (bus.out_valid === 1'b1) begin
        if (bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_extra: unexpected output %h", obs);
          end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
              errors++;
              $display("FAIL b2b_data_%0d: got %h, required %h", recv, obs, want);
            end
          end
          recv++;
        end else begin
          held_valid = 1'b1;
          held       = obs;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({2'b00, mants[sent]});
        sent++;
      end
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (sent != 6 || recv != 6 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: sent=%0d recv=%0d left=%0d, required 6/6/0", sent, recv, exp_q.size());
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_duplicate: %0d extra outputs, required 0", extra);
    end
  endtask

  task automatic test_reset_midflight();
    logic          seen;
    int            lat;
    logic [MW+1:0] got;
    int            stray = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a_operand = {8'h7F, 23'h123456 + 23'(i)};
      bus.b_operand = {8'h7F, 23'h000000};
      bus.approx_en = 1'b0;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.product_mantissa !== 23'h123456) begin
      errors++;
      $display("FAIL rst_pre: v=%0b m=%h, required v=1 m=123456", bus.out_valid, bus.product_mantissa);
    end
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.normalised, bus.round_carry, bus.product_mantissa} !== '0) begin
      errors++;
      $display("FAIL rst_async: v=%0b n=%0b c=%0b m=%h, required all 0",
               bus.out_valid, bus.normalised, bus.round_carry, bus.product_mantissa);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rst_flush: %0d outputs after release, required 0", stray);
    end
    send_one({8'h7F, 23'h400000}, {8'h7F, 23'h400000}, 1'b0, seen, lat, got);
    checks++;
    if (!seen || lat != 3 || got !== {2'b10, 23'h100000}) begin
      errors++;
      $display("FAIL rst_first: seen=%0b lat=%0d {n,c,m}=%h, required lat=3 %h",
               seen, lat, got, {2'b10, 23'h100000});
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_approx();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
